// File: rtl/dc_exp_pkg.sv
// rtl/dc_exp_pkg.sv - shared types and constants for the D-cache exception sequencer
package dc_exp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REQ   = 2'd2,
    ST_SVC   = 2'd3
  } dc_exp_state_e;

  localparam int EIP_W  = 32;
  localparam int ADDR_W = 32;
  localparam int VEC_W  = 8;

  localparam logic [VEC_W-1:0] PF_VEC = 8'd14;
  localparam logic [VEC_W-1:0] GP_VEC = 8'd13;
  localparam logic [VEC_W-1:0] DF_VEC = 8'd8;

  // Protection faults take priority over a simultaneous page fault.
  function automatic logic [VEC_W-1:0] fault_vec(input logic prot);
    return prot ? GP_VEC : PF_VEC;
  endfunction

endpackage

// File: rtl/dc_exp_drain_cnt.sv
// rtl/dc_exp_drain_cnt.sv - saturating drain counter with clear and done
// done_o is high in the increment cycle in which the count reaches MIN_DRAIN (or is already there).
module dc_exp_drain_cnt #(
  parameter int MIN_DRAIN = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MIN_DRAIN);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign done_o = inc_i & (cnt_d == SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dc_exp_seq.sv
// rtl/dc_exp_seq.sv - RO-stage D-cache exception sequencer (IDLE/DRAIN/REQ/SVC)
// Optional DC_EXP_DBLFAULT_EN: a fault taken while in service escalates to a double fault.
module dc_exp_seq
  import dc_exp_pkg::*;
#(
  parameter int MIN_DRAIN = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_ro,
  input  logic              dc_exp,
  input  logic              dc_prot_exp,
  input  logic              dc_page_fault,
  input  logic              dc_rd_exp,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [EIP_W-1:0]  ro_eip,
  input  logic              pipe_empty,
  input  logic              isr_ack,
  input  logic              iret_done,
  output logic              ro_stall,
  output logic              flush_younger,
  output logic              exp_req,
  output logic [VEC_W-1:0]  exp_vector,
  output logic [EIP_W-1:0]  exp_eip,
  output logic [ADDR_W-1:0] cr2,
  output logic              isr
);

  dc_exp_state_e     state_q, state_d;
  logic              dbl_q, dbl_d;
  logic              flush_q;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [EIP_W-1:0]  eip_q;
  logic [ADDR_W-1:0] cr2_q;
  logic              capture, ro_stall_c, cnt_done, exp_hit;

  assign exp_hit = v_ro & dc_exp;

  dc_exp_drain_cnt #(
    .MIN_DRAIN (MIN_DRAIN),
    .CNT_W     (CNT_W)
  ) u_drain_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (capture),
    .inc_i  (state_q == ST_DRAIN),
    .done_o (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    dbl_d      = dbl_q;
    vec_d      = vec_q;
    capture    = 1'b0;
    ro_stall_c = 1'b0;
    exp_req    = 1'b0;
    isr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exp_hit) begin
          capture    = 1'b1;
          ro_stall_c = 1'b1;
          vec_d      = fault_vec(dc_prot_exp);
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ro_stall_c = 1'b1;
        isr        = dbl_q;
        if (cnt_done && pipe_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        ro_stall_c = 1'b1;
        exp_req    = 1'b1;
        isr        = dbl_q;
        if (isr_ack) state_d = ST_SVC;
      end
      ST_SVC: begin
        isr = 1'b1;
        // IRET retirement has priority; a coincident fault re-evaluates from IDLE.
        if (iret_done) begin
          state_d = ST_IDLE;
          dbl_d   = 1'b0;
        end
`ifdef DC_EXP_DBLFAULT_EN
        else if (exp_hit && !dbl_q) begin
          capture    = 1'b1;
          ro_stall_c = 1'b1;
          dbl_d      = 1'b1;
          vec_d      = DF_VEC;
          state_d    = ST_DRAIN;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dbl_q   <= 1'b0;
      flush_q <= 1'b0;
      vec_q   <= '0;
      eip_q   <= '0;
      cr2_q   <= '0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
      flush_q <= capture;
      vec_q   <= vec_d;
      if (capture) begin
        eip_q <= ro_eip;
        if (dc_page_fault && !dc_prot_exp) begin
          cr2_q <= dc_rd_exp ? mem_rd_addr : mem_wr_addr;
        end
      end
    end
  end

  assign ro_stall      = ro_stall_c & rst_n;
  assign flush_younger = flush_q;
  assign exp_vector    = vec_q;
  assign exp_eip       = eip_q;
  assign cr2           = cr2_q;

endmodule
